// File: rtl/cache_refill_ctrl_pkg.sv
// Shared types, width helpers and victim selection for the L1 line-refill controller.
package cache_refill_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        WRITE,
        DRAIN
    } refill_state_e;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LINE_BEATS = 4;
    localparam int DEF_NUM_SETS   = 64;

    // Byte-offset bits within one line.
    function automatic int off_width(input int line_beats, input int data_width);
        return $clog2(line_beats * data_width / 8);
    endfunction

    function automatic int idx_width(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_width(input int addr_width, input int line_beats,
                                     input int data_width, input int num_sets);
        return addr_width - off_width(line_beats, data_width) - idx_width(num_sets);
    endfunction

    // An invalid way is always preferred over evicting live data.
    function automatic logic victim_sel(input logic [1:0] way_valid, input logic rand_way);
        if (!way_valid[0]) return 1'b0;
        if (!way_valid[1]) return 1'b1;
        return rand_way;
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Miss, memory and fill signals of the refill controller bundled as one interface.
interface cache_refill_ctrl_if
    import cache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LINE_BEATS = DEF_LINE_BEATS,
    parameter int NUM_SETS   = DEF_NUM_SETS
);
    localparam int IDX = idx_width(NUM_SETS);
    localparam int TAG = tag_width(ADDR_WIDTH, LINE_BEATS, DATA_WIDTH, NUM_SETS);

    logic                           flush;
    logic                           miss_valid;
    logic [ADDR_WIDTH-1:0]          miss_addr;
    logic                           miss_ready;
    logic [1:0]                     set_way_valid;
    logic                           rand_way;
    logic                           mem_req_valid;
    logic                           mem_req_ready;
    logic [ADDR_WIDTH-1:0]          mem_req_addr;
    logic                           mem_resp_valid;
    logic [DATA_WIDTH-1:0]          mem_resp_data;
    logic                           fill_we;
    logic                           fill_way;
    logic [IDX-1:0]                 fill_index;
    logic [TAG-1:0]                 fill_tag;
    logic [LINE_BEATS*DATA_WIDTH-1:0] fill_line;

    modport ctrl (
        input  flush, miss_valid, miss_addr, set_way_valid, rand_way,
               mem_req_ready, mem_resp_valid, mem_resp_data,
        output miss_ready, mem_req_valid, mem_req_addr,
               fill_we, fill_way, fill_index, fill_tag, fill_line
    );

    modport cache (
        output flush, miss_valid, miss_addr, set_way_valid, rand_way,
               mem_req_ready, mem_resp_valid, mem_resp_data,
        input  miss_ready, mem_req_valid, mem_req_addr,
               fill_we, fill_way, fill_index, fill_tag, fill_line
    );

endinterface

// File: rtl/cache_refill_ctrl_refill_line_buf.sv
// Beat counter plus slot buffer that assembles one cache line from memory beats.
module refill_line_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_BEATS = 4
) (
    input  logic                             clk,
    input  logic                             rst_aL,
    input  logic                             clr,
    input  logic                             we,
    input  logic [DATA_WIDTH-1:0]            data,
    output logic                             at_last,
    output logic [LINE_BEATS*DATA_WIDTH-1:0] line
);
    localparam int CW = $clog2(LINE_BEATS);

    logic [CW-1:0]                         count;
    logic [LINE_BEATS-1:0][DATA_WIDTH-1:0] slots;

    // High while the next beat written completes the line.
    assign at_last = (count == CW'(LINE_BEATS - 1));
    assign line    = slots;

    // NOTE: the slot array is reset too (it is only a few flops), so the fill_line
    // output reads zero after reset instead of leftover data from a dropped refill.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            count <= '0;
            slots <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (we) begin
            slots[count] <= data;
            count        <= count + CW'(1);
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Single-outstanding line-refill FSM: victim choice, memory request, beat collection, fill.
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LINE_BEATS = DEF_LINE_BEATS,
    parameter int NUM_SETS   = DEF_NUM_SETS
) (
    input  logic              clk,
    input  logic              rst_aL,
    cache_refill_ctrl_if.ctrl bus
);
    localparam int OFF = off_width(LINE_BEATS, DATA_WIDTH);
    localparam int IDX = idx_width(NUM_SETS);
    localparam int TAG = tag_width(ADDR_WIDTH, LINE_BEATS, DATA_WIDTH, NUM_SETS);

    refill_state_e         state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  way_q;
    logic                  accept;
    logic                  buf_clr;
    logic                  buf_we;
    logic                  buf_at_last;
    logic                  last_beat;

    refill_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_BEATS (LINE_BEATS)
    ) u_line_buf (
        .clk     (clk),
        .rst_aL  (rst_aL),
        .clr     (buf_clr),
        .we      (buf_we),
        .data    (bus.mem_resp_data),
        .at_last (buf_at_last),
        .line    (bus.fill_line)
    );

    assign last_beat = bus.mem_resp_valid && buf_at_last;

    // NOTE: every signal driven here gets its default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        buf_clr   = 1'b0;
        buf_we    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.miss_valid && !bus.flush) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    buf_clr   = 1'b1;
                    state_nxt = bus.flush ? DRAIN : RESP;
                end else if (bus.flush) begin
                    state_nxt = IDLE;
                end
            end
            RESP: begin
                buf_we = bus.mem_resp_valid;
                // A flush that coincides with the final beat leaves nothing to drain.
                if (last_beat)      state_nxt = bus.flush ? IDLE : WRITE;
                else if (bus.flush) state_nxt = DRAIN;
            end
            WRITE: state_nxt = IDLE;
            DRAIN: begin
                buf_we = bus.mem_resp_valid;
                if (last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state  <= IDLE;
            addr_q <= '0;
            way_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q <= bus.miss_addr;
                way_q  <= victim_sel(bus.set_way_valid, bus.rand_way);
            end
        end
    end

    assign bus.miss_ready    = (state == IDLE);
    assign bus.mem_req_valid = (state == REQ);
    assign bus.mem_req_addr  = {addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
    assign bus.fill_we       = (state == WRITE);
    assign bus.fill_way      = way_q;
    assign bus.fill_index    = addr_q[OFF +: IDX];
    assign bus.fill_tag      = addr_q[ADDR_WIDTH-1 -: TAG];

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: stimulus queues expectations, a monitor checks outputs.
module tb_cache_refill_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LB = 4;
    localparam int NS = 64;

    typedef struct {
        logic [31:0] addr;
        int          hs_cyc;
    } req_t;

    typedef struct {
        logic         way;
        logic [5:0]   index;
        logic [21:0]  tag;
        logic [127:0] line;
        int           cyc;
    } fill_t;

    logic clk;
    logic rst_aL;
    int   cyc;
    int   n_checks;
    int   n_fail;

    req_t  exp_req_q[$];
    fill_t exp_fill_q[$];

    cache_refill_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_BEATS(LB), .NUM_SETS(NS)) bus ();

    cache_refill_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LINE_BEATS (LB),
        .NUM_SETS   (NS)
    ) dut (
        .clk    (clk),
        .rst_aL (rst_aL),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event seen with no expectation queued (cycle %0d)", name, cyc);
    endtask

    // Monitor: samples mid-cycle, compares against queued expectations.
    always @(negedge clk) begin
        if (rst_aL) begin
            if (bus.mem_req_valid && exp_req_q.size() > 0) begin
                check("req_addr", bus.mem_req_addr, exp_req_q[0].addr);
                if (bus.mem_req_ready) begin
                    check("req_hs_cycle", cyc, exp_req_q[0].hs_cyc);
                    void'(exp_req_q.pop_front());
                end
            end else if (bus.mem_req_valid && bus.mem_req_ready) begin
                unexpected("req_handshake");
            end
            if (bus.fill_we) begin
                if (exp_fill_q.size() == 0) begin
                    unexpected("fill_we");
                end else begin
                    check("fill_cycle", cyc, exp_fill_q[0].cyc);
                    check("fill_way", bus.fill_way, exp_fill_q[0].way);
                    check("fill_index", bus.fill_index, exp_fill_q[0].index);
                    check("fill_tag", bus.fill_tag, exp_fill_q[0].tag);
                    check("fill_line", bus.fill_line, exp_fill_q[0].line);
                    void'(exp_fill_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_miss(input logic [31:0] addr, input logic [1:0] wv, input logic rw,
                              output int t0);
        tick();
        bus.miss_valid    = 1'b1;
        bus.miss_addr     = addr;
        bus.set_way_valid = wv;
        bus.rand_way      = rw;
        t0                = cyc;
    endtask

    // Full refill; way inputs are scrambled after accept to prove they were latched.
    task automatic do_refill(input logic [31:0] addr, input logic [1:0] wv, input logic rw,
                             input int wait_cyc, input logic flush_in_write,
                             input logic exp_way, input logic [31:0] exp_req,
                             input logic [5:0] exp_idx, input logic [21:0] exp_tag,
                             input logic [127:0] line);
        int t0;
        issue_miss(addr, wv, rw, t0);
        exp_req_q.push_back('{exp_req, t0 + 1 + wait_cyc});
        exp_fill_q.push_back('{exp_way, exp_idx, exp_tag, line, t0 + 6 + wait_cyc});
        tick();
        bus.miss_valid    = 1'b0;
        bus.set_way_valid = ~wv;
        bus.rand_way      = ~rw;
        check("miss_ready_busy", bus.miss_ready, 1'b0);
        for (int w = 0; w < wait_cyc; w++) begin
            check("req_valid_held", bus.mem_req_valid, 1'b1);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < LB; i++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = line[i*DW +: DW];
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        bus.flush          = flush_in_write;
        tick();
        bus.flush = 1'b0;
        check("miss_ready_after_fill", bus.miss_ready, 1'b1);
    endtask

    task automatic send_beat(input logic [31:0] data);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = data;
        tick();
        bus.mem_resp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        n_checks           = 0;
        n_fail             = 0;
        cyc                = 0;
        rst_aL             = 1'b0;
        bus.flush          = 1'b0;
        bus.miss_valid     = 1'b0;
        bus.miss_addr      = '0;
        bus.set_way_valid  = '0;
        bus.rand_way       = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;

        repeat (2) tick();
        check("rst_miss_ready", bus.miss_ready, 1'b1);
        check("rst_req_valid", bus.mem_req_valid, 1'b0);
        check("rst_fill_we", bus.fill_we, 1'b0);
        check("rst_fill_line", bus.fill_line, '0);
        rst_aL = 1'b1;

        // Both ways valid: random way wins; beats A..D land in slots 0..3.
        do_refill(32'h0000_1234, 2'b11, 1'b1, 0, 1'b0, 1'b1, 32'h0000_1230, 6'h23, 22'h4,
                  {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
        do_refill(32'h0000_ABCC, 2'b10, 1'b1, 0, 1'b0, 1'b0, 32'h0000_ABC0, 6'h3C, 22'h2A,
                  {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888});
        do_refill(32'h8000_0040, 2'b01, 1'b0, 0, 1'b0, 1'b1, 32'h8000_0040, 6'h04, 22'h20_0000,
                  {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000});
        do_refill(32'hFFFF_FFFF, 2'b00, 1'b1, 0, 1'b0, 1'b0, 32'hFFFF_FFF0, 6'h3F, 22'h3F_FFFF,
                  {32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0001, 32'h0123_4567});
        // Memory stalls the request for 5 cycles.
        do_refill(32'h0000_5678, 2'b11, 1'b0, 5, 1'b0, 1'b0, 32'h0000_5670, 6'h27, 22'h15,
                  {32'h4444_0000, 32'h3333_0000, 32'h2222_0000, 32'h1111_0000});
        // Flush during WRITE does not cancel the fill.
        do_refill(32'h0000_0F00, 2'b01, 1'b0, 0, 1'b1, 1'b1, 32'h0000_0F00, 6'h30, 22'h3,
                  {32'h0BAD_F00D, 32'h600D_F00D, 32'hDEAD_BEEF, 32'hFEED_FACE});

        // Flush after two beats: the other two are drained, no fill.
        issue_miss(32'h0000_2000, 2'b11, 1'b0, t0);
        exp_req_q.push_back('{32'h0000_2000, t0 + 1});
        tick();
        bus.miss_valid    = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        send_beat(32'h0000_0001);
        send_beat(32'h0000_0002);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        send_beat(32'h0000_0003);
        check("drain_miss_ready_busy", bus.miss_ready, 1'b0);
        send_beat(32'h0000_0004);
        check("drain_miss_ready_done", bus.miss_ready, 1'b1);

        // Flush in the handshake cycle: request counts, all four beats drained.
        issue_miss(32'h0000_2400, 2'b11, 1'b1, t0);
        exp_req_q.push_back('{32'h0000_2400, t0 + 1});
        tick();
        bus.miss_valid    = 1'b0;
        bus.mem_req_ready = 1'b1;
        bus.flush         = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.flush         = 1'b0;
        for (int i = 0; i < LB - 1; i++) send_beat(32'h5A5A_0000 + 32'(i));
        check("hs_flush_still_draining", bus.miss_ready, 1'b0);
        send_beat(32'h5A5A_0003);
        check("hs_flush_idle", bus.miss_ready, 1'b1);

        // Flush in REQ before handshake: back to IDLE, no request made.
        issue_miss(32'h0000_3300, 2'b11, 1'b0, t0);
        tick();
        bus.miss_valid = 1'b0;
        bus.flush      = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("req_flush_idle", bus.miss_ready, 1'b1);
        check("req_flush_no_valid", bus.mem_req_valid, 1'b0);

        // Flush and miss together: the miss is not accepted.
        issue_miss(32'h0000_3400, 2'b11, 1'b0, t0);
        bus.flush = 1'b1;
        tick();
        bus.miss_valid = 1'b0;
        bus.flush      = 1'b0;
        check("flush_beats_miss", bus.miss_ready, 1'b1);

        // Reset mid-RESP: outputs clear at once, stray beats ignored.
        issue_miss(32'h0000_3C00, 2'b11, 1'b1, t0);
        exp_req_q.push_back('{32'h0000_3C00, t0 + 1});
        tick();
        bus.miss_valid    = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        send_beat(32'h9999_0001);
        send_beat(32'h9999_0002);
        rst_aL = 1'b0;
        #1;
        check("midrst_miss_ready", bus.miss_ready, 1'b1);
        check("midrst_req_valid", bus.mem_req_valid, 1'b0);
        check("midrst_req_addr", bus.mem_req_addr, '0);
        check("midrst_fill_we", bus.fill_we, 1'b0);
        check("midrst_fill_way", bus.fill_way, 1'b0);
        check("midrst_fill_tag", bus.fill_tag, '0);
        check("midrst_fill_line", bus.fill_line, '0);
        tick();
        rst_aL = 1'b1;
        send_beat(32'h9999_0003);
        send_beat(32'h9999_0004);
        check("stray_beats_idle", bus.miss_ready, 1'b1);

        // Normal refill after the reset.
        do_refill(32'h0000_1234, 2'b10, 1'b1, 0, 1'b0, 1'b0, 32'h0000_1230, 6'h23, 22'h4,
                  {32'h0000_000D, 32'h0000_000C, 32'h0000_000B, 32'h0000_000A});

        repeat (3) tick();
        check("req_queue_drained", 128'(exp_req_q.size()), 128'd0);
        check("fill_queue_drained", 128'(exp_fill_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
